// File: rtl/axis_deconcatener.sv
// Splits one two-lane 32-bit ADC AXI4-Stream word into two per-channel sample streams,
// each with its own registered output slot and a sticky over-range flag.
module axis_deconcatener #(
    parameter int AXIS_TDATA_WIDTH_IN  = 14,
    parameter int AXIS_TDATA_WIDTH_OUT = 16,
    parameter int ALIGN_MSB            = 0
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    output logic                            s_axis_tready,
    input  logic [31:0]                     s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            m_axis_tready_0,
    output logic [AXIS_TDATA_WIDTH_OUT-1:0] m_axis_tdata_0,
    output logic                            m_axis_tvalid_0,
    input  logic                            m_axis_tready_1,
    output logic [AXIS_TDATA_WIDTH_OUT-1:0] m_axis_tdata_1,
    output logic                            m_axis_tvalid_1,
    input  logic                            ovr_clear,
    output logic                            ovr_0,
    output logic                            ovr_1
);

    localparam int IN  = AXIS_TDATA_WIDTH_IN;
    localparam int OUT = AXIS_TDATA_WIDTH_OUT;
    localparam int SH  = IN - 1;
    // Bits [15:IN-1] of a lane, shifted down, must equal all-zeros or this mask.
    localparam logic [15:0] HI_MASK = 16'hFFFF >> SH;

    logic [1:0]     tvalid_q, tvalid_d;
    logic [1:0]     ovr_q, ovr_d;
    logic [OUT-1:0] tdata_q [2];
    logic [OUT-1:0] tdata_d [2];
    logic [15:0]    lane [2];
    logic [1:0]     tready;
    logic [1:0]     free;
    logic           acc;

    function automatic logic [OUT-1:0] format_sample(input logic [15:0] l);
        logic [IN-1:0]  x;
        logic [OUT-1:0] ext;
        x   = l[IN-1:0];
        ext = OUT'(x);
        if (ALIGN_MSB != 0) begin
            ext = ext << (OUT - IN);
        end else begin
            for (int i = IN; i < OUT; i++) ext[i] = x[IN-1];
        end
        return ext;
    endfunction

    function automatic logic out_of_range(input logic [15:0] l);
        logic [15:0] hi;
        hi = l >> SH;
        return (IN < 16) && (hi != '0) && (hi != HI_MASK);
    endfunction

    assign lane[0] = s_axis_tdata[15:0];
    assign lane[1] = s_axis_tdata[31:16];
    assign tready  = {m_axis_tready_1, m_axis_tready_0};
    assign free    = ~tvalid_q | tready;

    // Both slots load together, so input is accepted only when both can take a beat.
    assign s_axis_tready = aresetn & free[0] & free[1];
    assign acc           = s_axis_tvalid & s_axis_tready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        tvalid_d = tvalid_q;
        ovr_d    = ovr_q;
        tdata_d  = tdata_q;
        for (int k = 0; k < 2; k++) begin
            if (acc) begin
                tvalid_d[k] = 1'b1;
                tdata_d[k]  = format_sample(lane[k]);
            end else if (tvalid_q[k] && tready[k]) begin
                tvalid_d[k] = 1'b0;
            end
            if (ovr_clear) ovr_d[k] = 1'b0;
            // A set in the same cycle as a clear wins.
            if (acc && out_of_range(lane[k])) ovr_d[k] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!aresetn) begin
            tvalid_q   <= '0;
            ovr_q      <= '0;
            tdata_q[0] <= '0;
            tdata_q[1] <= '0;
        end else begin
            tvalid_q   <= tvalid_d;
            ovr_q      <= ovr_d;
            tdata_q[0] <= tdata_d[0];
            tdata_q[1] <= tdata_d[1];
        end
    end

    assign m_axis_tvalid_0 = tvalid_q[0];
    assign m_axis_tvalid_1 = tvalid_q[1];
    assign m_axis_tdata_0  = tdata_q[0];
    assign m_axis_tdata_1  = tdata_q[1];
    assign ovr_0           = ovr_q[0];
    assign ovr_1           = ovr_q[1];

endmodule

// File: tb/tb_axis_deconcatener.sv
// Self-checking bench for axis_deconcatener: vector table, hand-written corner sequences,
// and a randomized run checked by a queue-based scoreboard and arithmetic sample model.
module tb_axis_deconcatener;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_tready, a_s_tready;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        r0, r1;
    logic [15:0] m_tdata_0, m_tdata_1, a_tdata_0, a_tdata_1;
    logic        m_tvalid_0, m_tvalid_1, a_tvalid_0, a_tvalid_1;
    logic        ovr_clear;
    logic        ovr_0, ovr_1, a_ovr_0, a_ovr_1;

    always #5 aclk = ~aclk;

    axis_deconcatener #(.AXIS_TDATA_WIDTH_IN(14), .AXIS_TDATA_WIDTH_OUT(16), .ALIGN_MSB(0)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .m_axis_tready_0(r0), .m_axis_tdata_0(m_tdata_0), .m_axis_tvalid_0(m_tvalid_0),
        .m_axis_tready_1(r1), .m_axis_tdata_1(m_tdata_1), .m_axis_tvalid_1(m_tvalid_1),
        .ovr_clear(ovr_clear), .ovr_0(ovr_0), .ovr_1(ovr_1)
    );

    axis_deconcatener #(.AXIS_TDATA_WIDTH_IN(14), .AXIS_TDATA_WIDTH_OUT(16), .ALIGN_MSB(1)) u_align (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tready(a_s_tready), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .m_axis_tready_0(r0), .m_axis_tdata_0(a_tdata_0), .m_axis_tvalid_0(a_tvalid_0),
        .m_axis_tready_1(r1), .m_axis_tdata_1(a_tdata_1), .m_axis_tvalid_1(a_tvalid_1),
        .ovr_clear(ovr_clear), .ovr_0(a_ovr_0), .ovr_1(a_ovr_1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: IN=14 sample is the lane value modulo 2^14, read as two's complement.
    function automatic logic [15:0] ref_sext(input logic [15:0] lane);
        int v;
        v = int'(lane) % 16384;
        if (v >= 8192) v -= 16384;
        return 16'(v);
    endfunction

    function automatic logic [15:0] ref_align(input logic [15:0] lane);
        return 16'((int'(lane) % 16384) * 4);
    endfunction

    function automatic logic ref_ovr(input logic [15:0] lane);
        int v;
        v = int'(lane);
        if (v >= 32768) v -= 65536;
        return (v < -8192) || (v > 8191);
    endfunction

    // Scoreboard state, owned by the monitor below.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] mexp;
    int          n_in = 0, n_out0 = 0, n_out1 = 0;
    bit          acc_seen = 0;
    bit          stall0 = 0, stall1 = 0;
    logic [15:0] held0, held1;
    bit          exp_ovr0 = 0, exp_ovr1 = 0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            q0.delete();
            q1.delete();
            stall0   = 0;
            stall1   = 0;
            acc_seen = 0;
            exp_ovr0 = 0;
            exp_ovr1 = 0;
        end else begin
            check("ovr_0 sticky", 32'(ovr_0), 32'(exp_ovr0));
            check("ovr_1 sticky", 32'(ovr_1), 32'(exp_ovr1));
            check("s_tready", 32'(s_tready), 32'((!m_tvalid_0 || r0) && (!m_tvalid_1 || r1)));
            if (stall0) check("ch0 hold", {m_tvalid_0, m_tdata_0}, {1'b1, held0});
            if (stall1) check("ch1 hold", {m_tvalid_1, m_tdata_1}, {1'b1, held1});
            if (m_tvalid_0 && r0) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL ch0 extra beat: got %h, expected no beat", m_tdata_0);
                end else begin
                    mexp = q0.pop_front();
                    check("ch0 data", m_tdata_0, ref_sext(mexp[15:0]));
                    check("ch0 align data", a_tdata_0, ref_align(mexp[15:0]));
                    n_out0++;
                end
            end
            if (m_tvalid_1 && r1) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL ch1 extra beat: got %h, expected no beat", m_tdata_1);
                end else begin
                    mexp = q1.pop_front();
                    check("ch1 data", m_tdata_1, ref_sext(mexp[31:16]));
                    check("ch1 align data", a_tdata_1, ref_align(mexp[31:16]));
                    n_out1++;
                end
            end
            stall0   = m_tvalid_0 && !r0;
            stall1   = m_tvalid_1 && !r1;
            held0    = m_tdata_0;
            held1    = m_tdata_1;
            acc_seen = s_tvalid && s_tready;
            if (acc_seen) begin
                q0.push_back(s_tdata);
                q1.push_back(s_tdata);
                n_in++;
            end
            exp_ovr0 = (ovr_clear ? 1'b0 : exp_ovr0) | (acc_seen && ref_ovr(s_tdata[15:0]));
            exp_ovr1 = (ovr_clear ? 1'b0 : exp_ovr1) | (acc_seen && ref_ovr(s_tdata[31:16]));
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        s_tvalid  = 1'b0;
        ovr_clear = 1'b0;
        r0        = 1'b1;
        r1        = 1'b1;
        repeat (3) tick();
    endtask

    typedef struct {
        logic [31:0] din;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic [15:0] exp_a0;
        logic        exp_ovr0;
        logic        exp_ovr1;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] rnd;
    int          base_in, base_o0, base_o1, not_ready;

    initial begin
        aresetn   = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        r0        = 1'b0;
        r1        = 1'b0;
        ovr_clear = 1'b0;

        // Beat accepted with ovr_clear high: flags show only this beat's range check.
        vecs[0] = '{32'hE001_1FFF, 16'h1FFF, 16'hE001, 16'h7FFC, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{32'h2000_1FFF, 16'h1FFF, 16'hE000, 16'h7FFC, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_4000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_7FFF, 16'hFFFF, 16'h0000, 16'hFFFC, 1'b1, 1'b1};
        vecs[5] = '{32'hDFFF_E000, 16'hE000, 16'h1FFF, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{32'h1234_ABCD, 16'hEBCD, 16'h1234, 16'hAF34, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("reset s_tready", 32'(s_tready), 32'd0);
        check("reset tvalid", {m_tvalid_0, m_tvalid_1}, 32'd0);
        check("reset tdata", {m_tdata_1, m_tdata_0}, 32'd0);
        check("reset ovr", {ovr_0, ovr_1}, 32'd0);
        aresetn = 1'b1;
        r0      = 1'b1;
        r1      = 1'b1;
        #1;
        check("post-reset s_tready", 32'(s_tready), 32'd1);
        tick();

        // Vector table: one-cycle latency, formatting, over-range
        for (int i = 0; i < 7; i++) begin
            s_tdata   = vecs[i].din;
            s_tvalid  = 1'b1;
            ovr_clear = 1'b1;
            tick();
            s_tvalid  = 1'b0;
            ovr_clear = 1'b0;
            @(negedge aclk);
            check($sformatf("vec%0d tvalid", i), {m_tvalid_0, m_tvalid_1}, 32'd3);
            check($sformatf("vec%0d tdata_0", i), m_tdata_0, vecs[i].exp0);
            check($sformatf("vec%0d tdata_1", i), m_tdata_1, vecs[i].exp1);
            check($sformatf("vec%0d align tdata_0", i), a_tdata_0, vecs[i].exp_a0);
            check($sformatf("vec%0d ovr", i), {ovr_0, ovr_1}, {vecs[i].exp_ovr0, vecs[i].exp_ovr1});
            @(posedge aclk);
            #1;
        end
        drain();

        // Sticky over-range: set, clear racing a new set, clear alone
        ovr_clear = 1'b1;
        tick();
        ovr_clear = 1'b0;
        s_tvalid  = 1'b1;
        s_tdata   = 32'h0000_4000;
        tick();
        s_tvalid  = 1'b0;
        @(negedge aclk);
        check("ovr set ch0", 32'(ovr_0), 32'd1);
        check("ovr ch1 untouched", 32'(ovr_1), 32'd0);
        @(posedge aclk);
        #1;
        ovr_clear = 1'b1;
        s_tvalid  = 1'b1;
        tick();
        ovr_clear = 1'b0;
        s_tvalid  = 1'b0;
        @(negedge aclk);
        check("ovr set wins over clear", 32'(ovr_0), 32'd1);
        @(posedge aclk);
        #1;
        ovr_clear = 1'b1;
        tick();
        ovr_clear = 1'b0;
        @(negedge aclk);
        check("ovr clear alone", 32'(ovr_0), 32'd0);
        @(posedge aclk);
        #1;

        // Full-throughput counting stream
        base_in   = n_in;
        base_o0   = n_out0;
        base_o1   = n_out1;
        not_ready = 0;
        for (int i = 0; i < 1000; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {16'(i + 1000), 16'(i)};
            if (!s_tready) not_ready++;
            tick();
        end
        drain();
        check("stream tready stalls", not_ready, 0);
        check("stream beats in", n_in - base_in, 1000);
        check("stream beats ch0", n_out0 - base_o0, 1000);
        check("stream beats ch1", n_out1 - base_o1, 1000);

        // Channel 1 stalled: ch0 delivers once, input blocked, ch1 held
        base_in  = n_in;
        base_o0  = n_out0;
        r0       = 1'b1;
        r1       = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h0123_0456;
        tick();
        s_tdata  = 32'h0789_0ABC;
        repeat (4) begin
            @(negedge aclk);
            check("stall s_tready", 32'(s_tready), 32'd0);
            check("stall tdata_1", {m_tvalid_1, m_tdata_1}, {1'b1, 16'h0123});
            @(posedge aclk);
            #1;
        end
        check("stall ch0 single beat", n_out0 - base_o0, 1);
        check("stall single accept", n_in - base_in, 1);
        r1 = 1'b1;
        #1;
        check("release s_tready", 32'(s_tready), 32'd1);
        @(posedge aclk);
        #1;
        check("release accept", n_in - base_in, 2);
        drain();

        // Randomized readies, valid and data against the scoreboard
        base_in = n_in;
        for (int cyc = 0; cyc < 50000 && (n_in - base_in) < 10000; cyc++) begin
            if (!s_tvalid || acc_seen) begin
                s_tvalid = ($urandom_range(3) != 0);
                rnd      = $urandom;
                if ($urandom_range(1) == 1) rnd[15:0] = ref_sext(rnd[15:0]);
                if ($urandom_range(1) == 1) rnd[31:16] = ref_sext(rnd[31:16]);
                s_tdata  = rnd;
            end
            r0        = ($urandom_range(3) != 0);
            r1        = ($urandom_range(3) != 0);
            ovr_clear = ($urandom_range(9) == 0);
            tick();
        end
        check("random beats within budget", 32'((n_in - base_in) >= 10000), 32'd1);
        drain();
        check("random ch0 drained", q0.size(), 0);
        check("random ch1 drained", q1.size(), 0);

        // Reset with a sample pending on ch0, then first beat after release
        r0       = 1'b0;
        r1       = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'h0001_0002;
        tick();
        aresetn  = 1'b0;
        s_tdata  = 32'h0003_0004;
        #1;
        check("in-reset s_tready", 32'(s_tready), 32'd0);
        check("pending before reset", 32'(m_tvalid_0), 32'd1);
        @(posedge aclk);
        #1;
        check("reset drops tvalid_0", 32'(m_tvalid_0), 32'd0);
        check("reset clears tdata_0", m_tdata_0, 32'd0);
        check("reset clears ovr", {ovr_0, ovr_1}, 32'd0);
        aresetn = 1'b1;
        r0      = 1'b1;
        #1;
        check("first beat s_tready", 32'(s_tready), 32'd1);
        tick();
        s_tvalid = 1'b0;
        @(negedge aclk);
        check("first beat tdata_0", {m_tvalid_0, m_tdata_0}, {1'b1, 16'h0004});
        check("first beat tdata_1", {m_tvalid_1, m_tdata_1}, {1'b1, 16'h0003});
        @(posedge aclk);
        #1;
        drain();
        check("final ch0 drained", q0.size(), 0);
        check("final ch1 drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
